avalon_regfile_slave: RTL and testbench
=======================================

# avalon_regfile_slave

Parametrised Avalon-MM slave register file: NUM_REGS registers of DATA_W bits with per-byte write enables, fixed-latency pipelined reads and burst transfers. It replaces the fixed two-register slave in Avalon MM peripherals. It sits directly on an Avalon-MM interconnect port and exposes the register array to local logic as a flat output bus.

## Interface
- DATA_W, 32: data width in bits; multiple of 8, range 8..128.
- NUM_REGS, 8: register count; power of two, range 2..256.
- READ_LATENCY, 1: cycles from read acceptance to the first READDATAVALID; range 1..4.
- BURST_W, 3: BURSTCOUNT width; maximum burst is 2^BURST_W-1 beats.
- CLK  in  1  single clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDRESS  in  32  byte address; register index = ADDRESS[log2(DATA_W/8) +: log2(NUM_REGS)].
- BYTE_ENABLE  in  DATA_W/8  per-byte write enable.
- READ  in  1  read request.
- WRITE  in  1  write request.
- WRITEDATA  in  DATA_W  write data.
- BURSTCOUNT  in  BURST_W  beat count, sampled on the first beat only.
- BEGINBURSTTRANSFER  in  1  first-beat marker; informational, not required for decode.
- READDATA  out  DATA_W  read data.
- READDATAVALID  out  1  READDATA qualifier.
- WAITREQUEST  out  1  command stall.
- REGS_OUT  out  NUM_REGS*DATA_W  flat register contents; register i occupies bits [i*DATA_W +: DATA_W].

## Operation
- A command is accepted when (READ or WRITE) and !WAITREQUEST.
- If READ and WRITE are asserted together, WRITE wins and the read is dropped.
- Address decode:
  - Register index bits as above.
  - Higher address bits beyond the register window are ignored. The register window therefore aliases across the address space.
  - Low byte-offset bits are ignored.
- Write: every byte lane whose BYTE_ENABLE bit is set updates. Any enable pattern is legal, including 0 (no change).
- State machine:
  - IDLE: accept a command. A read with BURSTCOUNT>1 moves to RBURST. A write with BURSTCOUNT>1 moves to WBURST. BURSTCOUNT 0 is treated as 1.
  - RBURST: issues one read beat per cycle with the index incrementing. WAITREQUEST=1 throughout. Returns to IDLE after the last beat is issued.
  - WBURST: WAITREQUEST=0. Each cycle with WRITE=1 writes one beat to the incrementing index; ADDRESS is ignored. Cycles with WRITE=0 are idle gaps. READ is ignored in this state. Returns to IDLE after the final beat is written.
- Index increment wraps modulo NUM_REGS.
- Read pipeline: READ_LATENCY-stage shift of {valid, data}. Data is the register value in the cycle the beat is issued, so a read issued the cycle after a write sees the new value.
- Reset values:
  - All registers and REGS_OUT: 0.
  - READDATA: 0; READDATAVALID: 0; WAITREQUEST: 0.
  - State: IDLE. Pipeline flushed.
- READDATA is 0 whenever READDATAVALID=0.

## Timing
- Single read accepted at cycle t: READDATAVALID=1 at t+READ_LATENCY for exactly one cycle.
- Read burst of N beats accepted at t:
  - WAITREQUEST=1 during t+1..t+N-1.
  - Valid beats at t+L..t+L+N-1, back to back with no gaps (L = READ_LATENCY).
  - The next command can be accepted at t+N.
- Back-to-back single reads: one accepted per cycle, one valid per cycle.
- Writes take effect on REGS_OUT at t+1; zero wait states.
- RESET asserted mid-burst: state returns to IDLE and READDATAVALID=0 from the next edge. In-flight beats are discarded and the burst is not resumed.
- WAITREQUEST is a registered output and never depends combinationally on READ/WRITE.

## Configuration
- AVS_REGFILE_BURST_EN defined: burst handling as described (RBURST/WBURST states).
- Not defined:
  - BURSTCOUNT and BEGINBURSTTRANSFER are ignored; every command is single-beat.
  - No burst state logic exists.
  - WAITREQUEST is tied to 0.

## Structure
- Package avalon_regfile_pkg:
  - state enum (IDLE, RBURST, WBURST);
  - function clog2;
  - localparams for byte-lane count and index width derived from DATA_W/NUM_REGS.
- One sub-module: avs_read_pipe, a parametrised READ_LATENCY-deep valid/data delay line with synchronous clear.

## Test plan
- Reset, then read all NUM_REGS=8 registers: every READDATA=0. With READ_LATENCY=2, each valid arrives 2 cycles after acceptance.
- Write 0xDEADBEEF to index 3 with BYTE_ENABLE=4'b1111, then write 0x11223344 with 4'b0101: read returns 0xDE22BE44. REGS_OUT[3] updates one cycle after each write.
- Read burst with BURSTCOUNT=4 at index 6 (NUM_REGS=8): beats return indices 6,7,0,1 (wrap), back to back. WAITREQUEST high for 3 cycles. A READ held during the stall is accepted only at t+4.
- Write burst with BURSTCOUNT=3 from index 1, with a one-cycle WRITE=0 gap after beat 1: indices 1,2,3 hold the beat data. Index 4 is unchanged. WAITREQUEST stays 0.
- RESET asserted in the second cycle of a 5-beat read burst: no READDATAVALID after reset. State is IDLE and a new single read completes normally.
- READ and WRITE asserted together to index 0 with data 0xA5A5A5A5: the write lands, READDATAVALID never rises for that cycle, and a subsequent read returns 0xA5A5A5A5.

Source files
------------

// File: rtl/avalon_regfile_pkg.sv
// avalon_regfile_pkg
//   Shared types and helpers for the Avalon-MM register file slave:
//   - state_e : burst controller states (IDLE, RBURST, WBURST)
//   - clog2   : ceiling log2 for deriving index/offset widths
//   - DEF_*   : default geometry (32-bit data, 8 registers) and the
//               byte-lane count / index width derived from it
package avalon_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RBURST,
        WBURST
    } state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 8;
    localparam int unsigned DEF_LANES    = DEF_DATA_W / 8;
    localparam int unsigned DEF_IDX_W    = clog2(DEF_NUM_REGS);

endpackage

// File: rtl/avs_read_pipe.sv
// avs_read_pipe
//   LATENCY-deep delay line carrying a read-beat valid flag and its data.
//   Synchronous clear empties every stage, discarding in-flight beats.
// Ports:
//   clk_i   - clock (rising edge)
//   clr_i   - synchronous clear, active high
//   valid_i - beat issued this cycle
//   data_i  - beat data (expected to be 0 when valid_i is 0)
//   valid_o - beat valid, LATENCY cycles after issue
//   data_o  - beat data, LATENCY cycles after issue
module avs_read_pipe #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [LATENCY-1:0]             valid_q;
    logic [LATENCY-1:0][DATA_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/avalon_regfile_slave.sv
// avalon_regfile_slave
//   Avalon-MM slave exposing NUM_REGS registers of DATA_W bits with per-byte
//   write enables, fixed-latency pipelined reads and optional bursts.
//   Build option: define AVS_REGFILE_BURST_EN to enable RBURST/WBURST
//   handling; otherwise every command is single-beat and WAITREQUEST is 0.
// Ports:
//   CLK, RESET            - clock, synchronous active-high reset
//   ADDRESS               - byte address; index taken above the byte offset,
//                           higher bits alias
//   BYTE_ENABLE           - per-byte write enable
//   READ, WRITE           - command strobes (WRITE wins when both set)
//   WRITEDATA             - write data
//   BURSTCOUNT            - beats per burst, sampled on the first beat
//   BEGINBURSTTRANSFER    - first-beat marker, unused for decode
//   READDATA/READDATAVALID- read return, READDATA is 0 when not valid
//   WAITREQUEST           - registered command stall
//   REGS_OUT              - flat register contents, reg i at [i*DATA_W +: DATA_W]
module avalon_regfile_slave
    import avalon_regfile_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BURST_W      = 3
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [31:0]                  ADDRESS,
    input  logic [DATA_W/8-1:0]          BYTE_ENABLE,
    input  logic                         READ,
    input  logic                         WRITE,
    input  logic [DATA_W-1:0]            WRITEDATA,
    input  logic [BURST_W-1:0]           BURSTCOUNT,
    input  logic                         BEGINBURSTTRANSFER,
    output logic [DATA_W-1:0]            READDATA,
    output logic                         READDATAVALID,
    output logic                         WAITREQUEST,
    output logic [NUM_REGS*DATA_W-1:0]   REGS_OUT
);

    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned IDX_W = clog2(NUM_REGS);
    localparam int unsigned OFF_W = clog2(LANES);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [IDX_W-1:0]  addr_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_en;
    logic              rd_issue;
    logic [DATA_W-1:0] rd_data;
    logic              unused_ok;

    assign addr_idx  = ADDRESS[OFF_W +: IDX_W];
    // Only the index field of ADDRESS is decoded; the rest is deliberately dropped.
    assign unused_ok = ^{ADDRESS, BURSTCOUNT, BEGINBURSTTRANSFER};

`ifdef AVS_REGFILE_BURST_EN
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BURST_W-1:0] left_q, left_d;
    logic              wait_q, wait_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        left_d   = left_q;
        wr_en    = 1'b0;
        wr_idx   = addr_idx;
        rd_issue = 1'b0;
        rd_idx   = addr_idx;
        case (state_q)
            IDLE: begin
                // In IDLE the registered stall is always low, so any strobe is accepted.
                if (WRITE) begin
                    wr_en = 1'b1;
                    if (BURSTCOUNT > BURST_W'(1)) begin
                        state_d = WBURST;
                        idx_d   = addr_idx + IDX_W'(1);
                        left_d  = BURSTCOUNT - BURST_W'(1);
                    end
                end else if (READ) begin
                    rd_issue = 1'b1;
                    if (BURSTCOUNT > BURST_W'(1)) begin
                        state_d = RBURST;
                        idx_d   = addr_idx + IDX_W'(1);
                        left_d  = BURSTCOUNT - BURST_W'(1);
                    end
                end
            end
            RBURST: begin
                rd_issue = 1'b1;
                rd_idx   = idx_q;
                idx_d    = idx_q + IDX_W'(1);
                left_d   = left_q - BURST_W'(1);
                if (left_q == BURST_W'(1)) begin
                    state_d = IDLE;
                end
            end
            WBURST: begin
                if (WRITE) begin
                    wr_en  = 1'b1;
                    wr_idx = idx_q;
                    idx_d  = idx_q + IDX_W'(1);
                    left_d = left_q - BURST_W'(1);
                    if (left_q == BURST_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Stall is registered from the next state, never from the live strobes.
        wait_d = (state_d == RBURST);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            left_q  <= '0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            left_q  <= left_d;
            wait_q  <= wait_d;
        end
    end

    assign WAITREQUEST = wait_q;
`else
    always_comb begin
        wr_en    = WRITE;
        rd_issue = READ & ~WRITE;
        wr_idx   = addr_idx;
        rd_idx   = addr_idx;
    end

    assign WAITREQUEST = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (BYTE_ENABLE[b]) begin
                    regs_q[wr_idx][b*8 +: 8] <= WRITEDATA[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        REGS_OUT = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            REGS_OUT[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    // Masking at issue keeps READDATA at 0 whenever no beat is valid.
    assign rd_data = rd_issue ? regs_q[rd_idx] : '0;

    avs_read_pipe #(
        .LATENCY (READ_LATENCY),
        .DATA_W  (DATA_W)
    ) u_read_pipe (
        .clk_i   (CLK),
        .clr_i   (RESET),
        .valid_i (rd_issue),
        .data_i  (rd_data),
        .valid_o (READDATAVALID),
        .data_o  (READDATA)
    );

endmodule

// File: tb/tb_avalon_regfile_slave.sv
`timescale 1ns/1ps
module tb_avalon_regfile_slave;
    import avalon_regfile_pkg::*;

    localparam int unsigned DW   = DEF_DATA_W;
    localparam int unsigned NR   = DEF_NUM_REGS;
    localparam int unsigned BEW  = DEF_LANES;
    localparam int unsigned IDXW = DEF_IDX_W;
    localparam int unsigned LAT  = 2;
    localparam int unsigned BW   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       address;
    logic [BEW-1:0]    byte_enable;
    logic              read;
    logic              write;
    logic [DW-1:0]     writedata;
    logic [BW-1:0]     burstcount;
    logic              begin_burst;
    logic [DW-1:0]     readdata;
    logic              readdatavalid;
    logic              waitrequest;
    logic [NR*DW-1:0]  regs_out;

    avalon_regfile_slave #(
        .DATA_W       (DW),
        .NUM_REGS     (NR),
        .READ_LATENCY (LAT),
        .BURST_W      (BW)
    ) dut (
        .CLK                (clk),
        .RESET              (reset),
        .ADDRESS            (address),
        .BYTE_ENABLE        (byte_enable),
        .READ               (read),
        .WRITE              (write),
        .WRITEDATA          (writedata),
        .BURSTCOUNT         (burstcount),
        .BEGINBURSTTRANSFER (begin_burst),
        .READDATA           (readdata),
        .READDATAVALID      (readdatavalid),
        .WAITREQUEST        (waitrequest),
        .REGS_OUT           (regs_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [DW-1:0] data;
    } beat_t;

    beat_t rq[$];
    int    zero_viol = 0;

    always @(negedge clk) begin
        if (readdatavalid === 1'b1) begin
            rq.push_back('{cyc, readdata});
        end else if (!reset && readdata !== '0) begin
            zero_viol++;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic logic [31:0] addr_of(input int idx);
        logic [IDXW-1:0] i;
        i = idx[IDXW-1:0];
        return {{(30-IDXW){1'b0}}, i, 2'b00};
    endfunction

    function automatic logic [DW-1:0] reg_at(input int idx);
        return regs_out[idx*DW +: DW];
    endfunction

    task automatic wr1(input int idx, input logic [DW-1:0] d, input logic [BEW-1:0] be);
        address     = addr_of(idx);
        writedata   = d;
        byte_enable = be;
        burstcount  = BW'(1);
        write       = 1'b1;
        begin_burst = 1'b1;
        step();
        write       = 1'b0;
        begin_burst = 1'b0;
    endtask

    task automatic rd1(input int idx, output int t);
        address     = addr_of(idx);
        burstcount  = BW'(1);
        read        = 1'b1;
        begin_burst = 1'b1;
        t           = cyc;
        step();
        read        = 1'b0;
        begin_burst = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input int exp_cyc, input logic [DW-1:0] exp_data);
        beat_t b;
        if (rq.size() == 0) begin
            check({tag, "_present"}, 64'd0, 64'd1);
        end else begin
            b = rq.pop_front();
            check({tag, "_data"}, 64'(b.data), 64'(exp_data));
            check({tag, "_cyc"}, 64'(b.cyc), 64'(exp_cyc));
        end
    endtask

    initial begin
        int t;
        int t0;
        reset       = 1'b1;
        address     = '0;
        byte_enable = '0;
        read        = 1'b0;
        write       = 1'b0;
        writedata   = '0;
        burstcount  = '0;
        begin_burst = 1'b0;
        idle_cycles(3);

        check("rst_valid", 64'(readdatavalid), 64'd0);
        check("rst_rdata", 64'(readdata), 64'd0);
        check("rst_wait", 64'(waitrequest), 64'd0);
        check("rst_regs_zero", 64'(regs_out == '0), 64'd1);
        reset = 1'b0;

        // Back-to-back reads of every register after reset.
        t0 = cyc;
        for (int i = 0; i < int'(NR); i++) begin
            address    = addr_of(i);
            burstcount = BW'(1);
            read       = 1'b1;
            step();
        end
        read = 1'b0;
        idle_cycles(LAT + 2);
        for (int i = 0; i < int'(NR); i++) begin
            expect_beat($sformatf("rst_rd%0d", i), t0 + int'(LAT) + i, '0);
        end
        check("rst_rd_extra", 64'(rq.size()), 64'd0);

        // Full write, then partial byte-enable merge.
        address     = addr_of(3);
        writedata   = 32'hDEADBEEF;
        byte_enable = 4'b1111;
        burstcount  = BW'(1);
        write       = 1'b1;
        check("w1_before", 64'(reg_at(3)), 64'h0);
        step();
        write = 1'b0;
        check("w1_after", 64'(reg_at(3)), 64'hDEADBEEF);
        wr1(3, 32'h11223344, 4'b0101);
        check("w2_merge", 64'(reg_at(3)), 64'hDE22BE44);
        wr1(3, 32'hFFFFFFFF, 4'b0000);
        check("be_zero", 64'(reg_at(3)), 64'hDE22BE44);
        rd1(3, t);
        idle_cycles(LAT + 1);
        expect_beat("rd3", t + int'(LAT), 32'hDE22BE44);

        // High address bits alias; low offset bits are ignored.
        address     = 32'hF000_0017;
        writedata   = 32'h0BADF00D;
        byte_enable = 4'b1111;
        burstcount  = BW'(1);
        write       = 1'b1;
        step();
        write = 1'b0;
        check("alias_idx5", 64'(reg_at(5)), 64'h0BADF00D);
        check("alias_idx3_kept", 64'(reg_at(3)), 64'hDE22BE44);

        // Read in the cycle right after a write sees the new value.
        address   = addr_of(2);
        writedata = 32'hC0FFEE02;
        write     = 1'b1;
        step();
        write = 1'b0;
        read  = 1'b1;
        t     = cyc;
        step();
        read = 1'b0;
        idle_cycles(LAT + 1);
        expect_beat("raw_rd2", t + int'(LAT), 32'hC0FFEE02);

        // READ and WRITE together: write lands, read dropped.
        address     = addr_of(0);
        writedata   = 32'hA5A5A5A5;
        byte_enable = 4'b1111;
        write       = 1'b1;
        read        = 1'b1;
        step();
        write = 1'b0;
        read  = 1'b0;
        idle_cycles(LAT + 2);
        check("rw_no_valid", 64'(rq.size()), 64'd0);
        check("rw_write", 64'(reg_at(0)), 64'hA5A5A5A5);
        rd1(0, t);
        idle_cycles(LAT + 1);
        expect_beat("rw_rd0", t + int'(LAT), 32'hA5A5A5A5);

`ifdef AVS_REGFILE_BURST_EN
        wr1(6, 32'h66666666, 4'b1111);
        wr1(7, 32'h77777777, 4'b1111);
        wr1(1, 32'h11111111, 4'b1111);

        // 4-beat read burst from index 6 wraps to 0,1; a held READ waits out the stall.
        address     = addr_of(6);
        burstcount  = BW'(4);
        read        = 1'b1;
        begin_burst = 1'b1;
        t           = cyc;
        step();
        begin_burst = 1'b0;
        address     = addr_of(3);
        burstcount  = BW'(1);
        check("rb_wait1", 64'(waitrequest), 64'd1);
        step();
        check("rb_wait2", 64'(waitrequest), 64'd1);
        step();
        check("rb_wait3", 64'(waitrequest), 64'd1);
        step();
        check("rb_wait_end", 64'(waitrequest), 64'd0);
        step();
        read = 1'b0;
        idle_cycles(LAT + 2);
        expect_beat("rb0", t + int'(LAT),     32'h66666666);
        expect_beat("rb1", t + int'(LAT) + 1, 32'h77777777);
        expect_beat("rb2", t + int'(LAT) + 2, 32'hA5A5A5A5);
        expect_beat("rb3", t + int'(LAT) + 3, 32'h11111111);
        expect_beat("rb_held", t + 4 + int'(LAT), 32'hDE22BE44);
        check("rb_extra", 64'(rq.size()), 64'd0);

        // 3-beat write burst from index 1 with a gap; ADDRESS and READ ignored mid-burst.
        wr1(4, 32'h44444444, 4'b1111);
        address     = addr_of(1);
        writedata   = 32'hB1B1B1B1;
        byte_enable = 4'b1111;
        burstcount  = BW'(3);
        write       = 1'b1;
        begin_burst = 1'b1;
        check("wb_wait0", 64'(waitrequest), 64'd0);
        step();
        write       = 1'b0;
        begin_burst = 1'b0;
        address     = addr_of(7);
        burstcount  = BW'(1);
        check("wb_reg1", 64'(reg_at(1)), 64'hB1B1B1B1);
        check("wb_wait_gap", 64'(waitrequest), 64'd0);
        step();
        write     = 1'b1;
        read      = 1'b1;
        writedata = 32'hB2B2B2B2;
        check("wb_wait1", 64'(waitrequest), 64'd0);
        step();
        read      = 1'b0;
        writedata = 32'hB3B3B3B3;
        check("wb_reg2", 64'(reg_at(2)), 64'hB2B2B2B2);
        check("wb_wait2", 64'(waitrequest), 64'd0);
        step();
        write = 1'b0;
        check("wb_reg3", 64'(reg_at(3)), 64'hB3B3B3B3);
        check("wb_reg4_kept", 64'(reg_at(4)), 64'h44444444);
        check("wb_reg7_kept", 64'(reg_at(7)), 64'h77777777);
        idle_cycles(LAT + 2);
        check("wb_no_read", 64'(rq.size()), 64'd0);

        // Reset in the second cycle of a 5-beat read burst.
        address     = addr_of(0);
        burstcount  = BW'(5);
        read        = 1'b1;
        begin_burst = 1'b1;
        step();
        read        = 1'b0;
        begin_burst = 1'b0;
        burstcount  = BW'(1);
        reset       = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_wait", 64'(waitrequest), 64'd0);
        idle_cycles(LAT + 5);
        check("rst_mid_no_valid", 64'(rq.size()), 64'd0);
        check("rst_mid_regs", 64'(reg_at(1)), 64'h0);
        wr1(5, 32'h5A5A0000, 4'b1111);
        rd1(5, t);
        idle_cycles(LAT + 1);
        expect_beat("post_rst_rd", t + int'(LAT), 32'h5A5A0000);
        check("post_rst_extra", 64'(rq.size()), 64'd0);
`else
        // Without burst support BURSTCOUNT is ignored: one beat, no stall.
        wr1(6, 32'h66666666, 4'b1111);
        address    = addr_of(6);
        burstcount = BW'(4);
        read       = 1'b1;
        t          = cyc;
        step();
        read       = 1'b0;
        burstcount = BW'(1);
        check("nb_wait", 64'(waitrequest), 64'd0);
        idle_cycles(LAT + 4);
        expect_beat("nb_rd", t + int'(LAT), 32'h66666666);
        check("nb_rd_extra", 64'(rq.size()), 64'd0);
        address     = addr_of(1);
        writedata   = 32'h1B1B1B1B;
        byte_enable = 4'b1111;
        burstcount  = BW'(3);
        write       = 1'b1;
        step();
        check("nb_wb_wait", 64'(waitrequest), 64'd0);
        step();
        write = 1'b0;
        check("nb_wb_reg1", 64'(reg_at(1)), 64'h1B1B1B1B);
        check("nb_wb_reg2_kept", 64'(reg_at(2)), 64'hC0FFEE02);
`endif

        check("rdata_zero_when_invalid", 64'(zero_viol), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
